// File: rtl/ga_pkg.sv
// GA coprocessor request/response types shared by the core-side issue unit
// and the coprocessor.
package ga_pkg;

   typedef logic [31:0] ga_multivector_t;

   typedef enum logic [2:0] {
      GA_ADD   = 3'd0,
      GA_SUB   = 3'd1,
      GA_GP    = 3'd2,
      GA_WEDGE = 3'd3,
      GA_DOT   = 3'd4,
      GA_REV   = 3'd5
   } ga_op_e;

   typedef struct packed {
      logic            valid;
      ga_op_e          op;
      logic [4:0]      rd;
      ga_multivector_t op_a;
      ga_multivector_t op_b;
   } ga_req_t;

   typedef struct packed {
      logic            valid;
      logic            ready;
      logic            busy;
      logic            error;
      logic            overflow;
      logic            underflow;
      ga_multivector_t result;
   } ga_resp_t;

endpackage

// File: rtl/ga_issue_unit.sv
// ga_issue_unit: core-side initiator for the GA coprocessor.
// Takes one decoded command, presents it as a request until the coprocessor
// accepts it, waits for the response with a timeout and holds the result for
// core writeback. One transaction in flight at a time.
// Optional performance counters are built when GA_ISSUE_PERF_EN is defined.
module ga_issue_unit #(
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned CntWidth      = 16
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   cmd_valid_i,
   output logic                                   cmd_ready_o,
   input  logic [$bits(ga_pkg::ga_req_t)-1:0]     cmd_i,
   input  logic                                   flush_i,
   output logic [$bits(ga_pkg::ga_req_t)-1:0]     ga_req_o,
   input  logic [$bits(ga_pkg::ga_resp_t)-1:0]    ga_resp_i,
   output logic                                   rsp_valid_o,
   input  logic                                   rsp_ready_i,
   output logic [$bits(ga_pkg::ga_multivector_t)-1:0] rsp_result_o,
   output logic                                   rsp_error_o,
   output logic                                   rsp_timeout_o,
   output logic                                   rsp_ovf_o,
   output logic                                   rsp_unf_o,
   output logic                                   busy_o,
   output logic                                   stale_o,
   output logic [31:0]                            perf_issued_o,
   output logic [31:0]                            perf_errors_o,
   output logic [31:0]                            perf_timeouts_o,
   output logic [CntWidth-1:0]                    perf_lat_max_o
);

   localparam logic [CntWidth-1:0] ToLast = CntWidth'(TimeoutCycles - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RESP
   } state_e;

   state_e state_q, state_d;

   ga_pkg::ga_req_t          cmd, payload_q, req_out;
   ga_pkg::ga_resp_t         resp;
   ga_pkg::ga_multivector_t  result_q;
   logic                     error_q, timeout_q, ovf_q, unf_q, stale_q;
   logic [CntWidth-1:0]      cnt_q;
   logic                     accept, issue, rsp_hit, to_hit;
   logic                     unused_busy;

   assign cmd         = ga_pkg::ga_req_t'(cmd_i);
   assign resp        = ga_pkg::ga_resp_t'(ga_resp_i);
   assign unused_busy = resp.busy;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and one-cycle event strobes for the datapath
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      issue   = 1'b0;
      rsp_hit = 1'b0;
      to_hit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i && !flush_i) begin
               accept  = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (resp.ready) begin
               issue   = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A flush drops the command even if the response lands this cycle;
            // a response beats a coincident timeout.
            if (flush_i) begin
               state_d = IDLE;
            end else if (resp.valid) begin
               rsp_hit = 1'b1;
               state_d = RESP;
            end else if (cnt_q == ToLast) begin
               to_hit  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Command payload, WAIT cycle counter, captured response and stale pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         payload_q <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         error_q   <= 1'b0;
         timeout_q <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         stale_q   <= 1'b0;
      end else begin
         if (accept) begin
            payload_q <= cmd;
         end
         if (issue) begin
            cnt_q <= '0;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + CntWidth'(1);
         end
         if (rsp_hit) begin
            result_q  <= resp.result;
            error_q   <= resp.error;
            timeout_q <= 1'b0;
            ovf_q     <= resp.overflow;
            unf_q     <= resp.underflow;
         end else if (to_hit) begin
            result_q  <= '0;
            error_q   <= 1'b1;
            timeout_q <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
         end
         stale_q <= resp.valid && (state_q != WAIT);
      end
   end

   // Request output: held payload, valid only while presenting in REQ
   always_comb begin
      req_out       = payload_q;
      req_out.valid = (state_q == REQ);
   end

   assign ga_req_o      = req_out;
   assign cmd_ready_o   = (state_q == IDLE);
   assign busy_o        = (state_q != IDLE);
   assign rsp_valid_o   = (state_q == RESP);
   assign rsp_result_o  = result_q;
   assign rsp_error_o   = error_q;
   assign rsp_timeout_o = timeout_q;
   assign rsp_ovf_o     = ovf_q;
   assign rsp_unf_o     = unf_q;
   assign stale_o       = stale_q;

`ifdef GA_ISSUE_PERF_EN
   logic [31:0]         issued_q, errors_q, timeouts_q;
   logic [CntWidth-1:0] lat_max_q, lat_cur;

   // Latency counts WAIT cycles including the one the response arrived in
   assign lat_cur = cnt_q + CntWidth'(1);

   // Performance counters; 32-bit counters wrap naturally
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         issued_q   <= '0;
         errors_q   <= '0;
         timeouts_q <= '0;
         lat_max_q  <= '0;
      end else begin
         if (issue) begin
            issued_q <= issued_q + 32'd1;
         end
         if (to_hit || (rsp_hit && resp.error)) begin
            errors_q <= errors_q + 32'd1;
         end
         if (to_hit) begin
            timeouts_q <= timeouts_q + 32'd1;
         end
         if (rsp_hit && (lat_cur > lat_max_q)) begin
            lat_max_q <= lat_cur;
         end
      end
   end

   assign perf_issued_o   = issued_q;
   assign perf_errors_o   = errors_q;
   assign perf_timeouts_o = timeouts_q;
   assign perf_lat_max_o  = lat_max_q;
`else
   assign perf_issued_o   = '0;
   assign perf_errors_o   = '0;
   assign perf_timeouts_o = '0;
   assign perf_lat_max_o  = '0;
`endif

endmodule
